// File: rtl/filter_pkg.sv
// filter_pkg: mode and FSM state encodings shared by the frame filter and its datapath.
package filter_pkg;
   typedef enum logic [1:0] {MODE_BYP = 2'b00, MODE_LP = 2'b01, MODE_HP = 2'b10, MODE_RSV = 2'b11} mode_e;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/iir_step.sv
// iir_step: one-sample first-order IIR step producing the saturated low-pass state and the mode-selected output.
module iir_step
   import filter_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int COEF_W = 12,
   parameter int FRAC   = 11
) (
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] prev,
   input  logic        [COEF_W-1:0] alpha,
   input  mode_e                    mode,
   output logic signed [DATA_W-1:0] y,
   output logic signed [DATA_W-1:0] lp,
   output logic                     clamp
);
   localparam int PW = DATA_W + COEF_W + 2;
   localparam logic signed [PW-1:0] HI   = PW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] LO   = -HI - 1;
   localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC - 1));
   logic signed [DATA_W:0]   diff;
   logic signed [PW-1:0]     prod, lp_w, hp_w;
   logic signed [DATA_W-1:0] hp;
   logic                     lp_c, hp_c;
   function automatic logic signed [DATA_W-1:0] clip(input logic signed [PW-1:0] v);
      return v > HI ? DATA_W'(HI) : v < LO ? DATA_W'(LO) : DATA_W'(v);
   endfunction
   always_comb begin
      diff  = (DATA_W + 1)'(x) - (DATA_W + 1)'(prev);
      prod  = PW'(signed'({1'b0, alpha})) * PW'(diff);
      lp_w  = PW'(prev) + ((prod + HALF) >>> FRAC);
      lp    = clip(lp_w);
      lp_c  = lp_w > HI || lp_w < LO;
      hp_w  = PW'(x) - PW'(lp);
      hp    = clip(hp_w);
      hp_c  = hp_w > HI || hp_w < LO;
      y     = mode == MODE_LP ? lp : mode == MODE_HP ? hp : x;
      clamp = mode == MODE_LP ? lp_c : mode == MODE_HP ? (lp_c || hp_c) : 1'b0;
   end
endmodule

// File: rtl/iir_frame_filter.sv
// iir_frame_filter: streams one frame from the sample buffer through iir_step into the result buffer.
module iir_frame_filter
   import filter_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 256,
   parameter int COEF_W = 12,
   parameter int FRAC   = 11
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [1:0]                 mode,
   input  logic [COEF_W-1:0]          alpha,
   output logic                       rd_en,
   output logic [$clog2(DEPTH)-1:0]   rd_addr,
   input  logic signed [DATA_W-1:0]   rd_data,
   output logic                       wr_en,
   output logic [$clog2(DEPTH)-1:0]   wr_addr,
   output logic signed [DATA_W-1:0]   wr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       sat
);
   localparam int AW = $clog2(DEPTH);
   state_e                   state, state_nx;
   mode_e                    mode_q;
   logic [COEF_W-1:0]        alpha_q;
   logic                     v1;
   logic [AW-1:0]            a1;
   logic signed [DATA_W-1:0] lp, lp_nx, y, prev;
   logic                     clamp, last_rd, last_wr, accept, stop;
   always_comb begin
      busy     = state == RUN || state == FLUSH;
      done     = state == DONE;
      last_rd  = rd_en && rd_addr == AW'(DEPTH - 1);
      last_wr  = wr_en && wr_addr == AW'(DEPTH - 1);
      accept   = start && (state == IDLE || state == DONE);
      stop     = abort && busy;
      prev     = a1 == '0 ? rd_data : lp;
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? RUN : IDLE;
         RUN:     state_nx = abort ? IDLE : last_rd ? FLUSH : RUN;
         FLUSH:   state_nx = abort ? IDLE : last_wr ? DONE : FLUSH;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   // a1 tracks the address whose data is on rd_data; address 0 seeds the low-pass state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
         v1      <= 1'b0;
         a1      <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         lp      <= '0;
         mode_q  <= MODE_BYP;
         alpha_q <= '0;
         sat     <= 1'b0;
      end else if (accept) begin
         rd_en   <= 1'b1;
         rd_addr <= '0;
         v1      <= 1'b0;
         wr_en   <= 1'b0;
         mode_q  <= mode_e'(mode);
         alpha_q <= alpha;
         sat     <= 1'b0;
      end else if (stop) begin
         rd_en <= 1'b0;
         v1    <= 1'b0;
         wr_en <= 1'b0;
      end else begin
         rd_en   <= rd_en && !last_rd;
         rd_addr <= rd_en ? rd_addr + 1'b1 : rd_addr;
         v1      <= rd_en;
         a1      <= rd_addr;
         wr_en   <= v1;
         if (v1) begin
            wr_addr <= a1;
            wr_data <= y;
            lp      <= lp_nx;
            sat     <= sat | clamp;
         end
      end
   end
   iir_step #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC)) u_step (
      .x     (rd_data),
      .prev  (prev),
      .alpha (alpha_q),
      .mode  (mode_q),
      .y     (y),
      .lp    (lp_nx),
      .clamp (clamp)
   );
endmodule

// File: tb/tb_iir_frame_filter.sv
// tb_iir_frame_filter: table-driven frames checked through a write scoreboard, plus abort and reset sequences.
module tb_iir_frame_filter;
   localparam int DW = 12, DEPTH = 8, CW = 12, FR = 11;
   logic                 clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0]           mode = 2'b00;
   logic [CW-1:0]        alpha = '0;
   logic                 rd_en, wr_en, busy, done, sat;
   logic [2:0]           rd_addr, wr_addr;
   logic signed [DW-1:0] rd_data = '0;
   logic signed [DW-1:0] wr_data;
   logic signed [DW-1:0] mem [DEPTH];
   int                   checks = 0, fails = 0;
   typedef struct packed {
      logic [1:0]                 mode;
      logic [CW-1:0]              alpha;
      logic [DEPTH-1:0][DW-1:0]   x;
      logic [DEPTH-1:0][DW-1:0]   y;
      logic                       sat;
   } vec_t;
   typedef struct packed {
      logic [2:0]    addr;
      logic [DW-1:0] data;
   } wr_t;
   vec_t vecs [8];
   wr_t  sb [$];
   wr_t  exp_w;
   iir_frame_filter #(.DATA_W(DW), .DEPTH(DEPTH), .COEF_W(CW), .FRAC(FR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .alpha(alpha),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .sat(sat)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
   always @(negedge clk) begin
      if (wr_en) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected got addr=%0d data=%0d", wr_addr, wr_data);
         end else begin
            exp_w = sb.pop_front();
            if ({wr_addr, wr_data} !== exp_w) begin
               fails++;
               $display("FAIL write got addr=%0d data=%0d expected addr=%0d data=%0d",
                        wr_addr, wr_data, exp_w.addr, $signed(exp_w.data));
            end
         end
      end
   end
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask
   function automatic vec_t mk(input logic [1:0] m, input int a, input int x[DEPTH], input int y[DEPTH], input logic s);
      vec_t v;
      v.mode  = m;
      v.alpha = CW'(a);
      v.sat   = s;
      for (int i = 0; i < DEPTH; i++) begin
         v.x[i] = DW'(x[i]);
         v.y[i] = DW'(y[i]);
      end
      return v;
   endfunction
   // start is raised in cycle 0; cycle k is sampled at the negedge after edge k-1 -> k
   task automatic run(input vec_t v, input int nexp, input int ncyc, input int abort_at, input int restart_at,
                      input int rst_at, input logic [15:0] rd_x, input logic [15:0] wr_x,
                      input logic [15:0] busy_x, input logic [15:0] done_x, input logic sat_x);
      logic [15:0] rd_m = '0, wr_m = '0, busy_m = '0, done_m = '0;
      logic        addr_ok = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = v.x[i];
         if (i < nexp) sb.push_back({3'(i), v.y[i]});
      end
      mode  = v.mode;
      alpha = v.alpha;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         abort = (k == abort_at);
         mode  = 2'($urandom);
         alpha = CW'($urandom);
         if (k == 1) chk("sat_cleared_on_start", sat, 0);
         rd_m[k]   = rd_en;
         wr_m[k]   = wr_en;
         busy_m[k] = busy;
         done_m[k] = done;
         if (rd_en && rd_addr != 3'(k - 1)) addr_ok = 1'b0;
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk("async_reset_outputs", {rd_en, wr_en, busy, done, sat, rd_addr, wr_addr, wr_data}, 0);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      chk("rd_en_cycles", rd_m, rd_x);
      chk("wr_en_cycles", wr_m, wr_x);
      chk("busy_cycles", busy_m, busy_x);
      chk("done_cycles", done_m, done_x);
      chk("rd_addr_sequence", addr_ok, 1);
      chk("sat_after_frame", sat, sat_x);
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
   endtask
   initial begin
      vecs[0] = mk(2'b01, 1024, '{0, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
                   '{0, 500, 750, 875, 938, 969, 985, 993}, 1'b0);
      vecs[1] = mk(2'b10, 1024, '{0, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
                   '{0, 500, 250, 125, 62, 31, 15, 7}, 1'b0);
      vecs[2] = mk(2'b10, 0, '{-2048, 2047, 2047, 2047, 2047, 2047, 2047, 2047},
                   '{0, 2047, 2047, 2047, 2047, 2047, 2047, 2047}, 1'b1);
      vecs[3] = mk(2'b01, 2048, '{5, -300, 700, -2048, 2047, 0, -1, 12},
                   '{5, -300, 700, -2048, 2047, 0, -1, 12}, 1'b0);
      vecs[4] = mk(2'b10, 2048, '{5, -300, 700, -2048, 2047, 0, -1, 12},
                   '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
      vecs[5] = mk(2'b00, 777, '{-2048, 2047, -1, 0, 100, -100, 1, -2},
                   '{-2048, 2047, -1, 0, 100, -100, 1, -2}, 1'b0);
      vecs[6] = mk(2'b11, 1500, '{-2048, 2047, -1, 0, 100, -100, 1, -2},
                   '{-2048, 2047, -1, 0, 100, -100, 1, -2}, 1'b0);
      vecs[7] = mk(2'b01, 4095, '{0, 2000, 2000, 2000, 2000, 2000, 2000, 2000},
                   '{0, 2047, 1953, 2047, 1953, 2047, 1953, 2047}, 1'b1);
      repeat (2) @(negedge clk);
      chk("reset_outputs", {rd_en, wr_en, busy, done, sat, rd_addr, wr_addr, wr_data}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         run(vecs[i], 8, 13, 0, 0, 0, 16'h01FE, 16'h07F8, 16'h07FE, 16'h0800, vecs[i].sat);
      run(vecs[2], 3, 8, 5, 0, 0, 16'h003E, 16'h0038, 16'h003E, 16'h0000, 1'b1);
      run(vecs[0], 8, 13, 0, 0, 0, 16'h01FE, 16'h07F8, 16'h07FE, 16'h0800, 1'b0);
      run(vecs[2], 2, 13, 0, 2, 4, 16'h001E, 16'h0018, 16'h001E, 16'h0000, 1'b0);
      rst_n = 1'b1;
      run(vecs[1], 8, 13, 0, 0, 0, 16'h01FE, 16'h07F8, 16'h07FE, 16'h0800, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
